core_pc_sched: RTL and testbench

CORE_PC_SCHED -- requirements
Module: core_pc_sched

---
 rtl/core_pc_sched.sv | 126 ++++++++++++
 tb/tb_core_pc_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_pc_sched.sv
// core_pc_sched: program-counter scheduler.
// Loads RESET_PC, fetches the current PC, waits for the instruction to retire,
// picks the next PC (trap > aligned redirect > misaligned redirect > PC+4) and
// writes it back once downstream stops stalling.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   stall                      holds the PC write while in UPDATE
//   retire                     current instruction finished (sampled in EXEC)
//   redirect_valid/_pc         taken branch/jump and its target
//   trap_valid/trap_vec        exception/interrupt and handler address
//   ifetch_ack                 instruction memory accepted the request
//   ifetch_req/ifetch_addr     fetch request and address (current PC)
//   pc_wen/pc_next             PC register write strobe and value
//   misalign                   one-cycle pulse: redirect target not word-aligned
//
// state  | meaning
// LOAD   | write RESET_PC into the PC register (one cycle)
// FETCH  | request instruction at PC, wait for ifetch_ack
// EXEC   | wait for retire, latch the next-PC choice
// UPDATE | write latched next PC when stall is low
module core_pc_sched #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        retire,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        trap_valid,
    input  logic [31:0] trap_vec,
    input  logic        ifetch_ack,
    output logic        ifetch_req,
    output logic [31:0] ifetch_addr,
    output logic        pc_wen,
    output logic [31:0] pc_next,
    output logic        misalign
);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_FETCH  = 2'd1,
        S_EXEC   = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic        mis_q, mis_d;

    logic        redir_aligned;
    logic [31:0] pc_inc;

    assign redir_aligned = (redirect_pc[1:0] == 2'b00);
    assign pc_inc        = pc_q + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
            pc_q    <= RESET_PC;
            tgt_q   <= RESET_PC;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        mis_d   = 1'b0;
        case (state_q)
            S_LOAD: begin
                pc_d    = RESET_PC;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (ifetch_ack) state_d = S_EXEC;
            end
            S_EXEC: begin
                if (retire) begin
                    state_d = S_UPDATE;
                    if (trap_valid) begin
                        tgt_d = trap_vec;
                    end else if (redirect_valid && redir_aligned) begin
                        tgt_d = redirect_pc;
                    end else if (redirect_valid) begin
                        tgt_d = trap_vec;
                        mis_d = 1'b1;
                    end else begin
                        tgt_d = pc_inc;
                    end
                end
            end
            S_UPDATE: begin
                if (!stall) begin
                    pc_d    = tgt_q;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    assign ifetch_req  = (state_q == S_FETCH);
    assign ifetch_addr = pc_q;
    assign misalign    = mis_q;

    // The state register sits in LOAD throughout reset, so the write strobe is
    // qualified with rst_n: no write while held in reset, and the LOAD write
    // lands on the first edge after release.
    assign pc_wen = rst_n & ((state_q == S_LOAD) | ((state_q == S_UPDATE) & ~stall));

    always_comb begin
        pc_next = pc_q;
        if (state_q == S_LOAD)        pc_next = RESET_PC;
        else if (state_q == S_UPDATE) pc_next = tgt_q;
    end

endmodule

// File: tb/tb_core_pc_sched.sv
module tb_core_pc_sched;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        retire = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_vec = 32'h0;
    logic        ifetch_ack = 1'b0;
    logic        ifetch_req;
    logic [31:0] ifetch_addr;
    logic        pc_wen;
    logic [31:0] pc_next;
    logic        misalign;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_pc = RST_PC;
    logic [31:0] exp_pc = RST_PC;
    logic        exp_mis = 1'b0;

    core_pc_sched #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .retire         (retire),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .trap_vec       (trap_vec),
        .ifetch_ack     (ifetch_ack),
        .ifetch_req     (ifetch_req),
        .ifetch_addr    (ifetch_addr),
        .pc_wen         (pc_wen),
        .pc_next        (pc_next),
        .misalign       (misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Next PC from the selection rules, as plain arithmetic: {misalign, pc}.
    function automatic logic [32:0] ref_next(input logic [31:0] pc, input logic trap,
                                             input logic rv, input logic [31:0] rpc,
                                             input logic [31:0] tvec);
        logic [31:0] inc;
        inc = pc + 32'd4;
        if (trap)                  return {1'b0, tvec};
        if (rv && (rpc % 4 == 0))  return {1'b0, rpc};
        if (rv)                    return {1'b1, tvec};
        return {1'b0, inc};
    endfunction

    // Inputs that must not matter in the current phase.
    task automatic noise();
        stall          = 1'($urandom_range(0, 1));
        redirect_valid = 1'($urandom_range(0, 1));
        trap_valid     = 1'($urandom_range(0, 1));
        redirect_pc    = $urandom;
        trap_vec       = $urandom;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fetch(input int delay, input logic give_ack);
        for (int i = 0; i <= delay; i++) begin
            noise();
            retire     = 1'($urandom_range(0, 1));
            ifetch_ack = give_ack && (i == delay);
            #1;
            chkb("fetch_req", ifetch_req, 1'b1);
            chk("fetch_addr", ifetch_addr, model_pc);
            chkb("fetch_wen", pc_wen, 1'b0);
            chkb("fetch_misalign", misalign, 1'b0);
            next_cycle();
        end
        ifetch_ack = 1'b0;
        retire     = 1'b0;
    endtask

    task automatic exec(input int waits, input logic trap, input logic rv,
                        input logic [31:0] rpc, input logic [31:0] tvec);
        for (int i = 0; i < waits; i++) begin
            noise();
            retire     = 1'b0;
            ifetch_ack = 1'($urandom_range(0, 1));
            #1;
            chkb("exec_req", ifetch_req, 1'b0);
            chkb("exec_wen", pc_wen, 1'b0);
            next_cycle();
        end
        noise();
        ifetch_ack     = 1'($urandom_range(0, 1));
        retire         = 1'b1;
        trap_valid     = trap;
        redirect_valid = rv;
        redirect_pc    = rpc;
        trap_vec       = tvec;
        #1;
        chkb("retire_req", ifetch_req, 1'b0);
        chkb("retire_wen", pc_wen, 1'b0);
        {exp_mis, exp_pc} = ref_next(model_pc, trap, rv, rpc, tvec);
        next_cycle();
        retire = 1'b0;
    endtask

    task automatic update(input int stalls, input logic finish);
        for (int i = 0; i < stalls; i++) begin
            noise();
            stall      = 1'b1;
            retire     = 1'($urandom_range(0, 1));
            ifetch_ack = 1'($urandom_range(0, 1));
            #1;
            chkb("stall_wen", pc_wen, 1'b0);
            chkb("stall_req", ifetch_req, 1'b0);
            chkb("stall_misalign", misalign, (i == 0) && exp_mis);
            next_cycle();
        end
        if (finish) begin
            noise();
            stall      = 1'b0;
            retire     = 1'($urandom_range(0, 1));
            ifetch_ack = 1'($urandom_range(0, 1));
            #1;
            chkb("update_wen", pc_wen, 1'b1);
            chk("update_pc_next", pc_next, exp_pc);
            chkb("update_misalign", misalign, (stalls == 0) && exp_mis);
            next_cycle();
            model_pc = exp_pc;
        end
        retire     = 1'b0;
        ifetch_ack = 1'b0;
    endtask

    task automatic chk_reset_outs();
        chkb("rst_req", ifetch_req, 1'b0);
        chkb("rst_wen", pc_wen, 1'b0);
        chkb("rst_misalign", misalign, 1'b0);
        chk("rst_pc_next", pc_next, RST_PC);
        chk("rst_addr", ifetch_addr, RST_PC);
    endtask

    // Assert reset, hold one edge, release and check the LOAD write.
    task automatic reset_pulse();
        rst_n = 1'b0;
        noise();
        retire     = 1'($urandom_range(0, 1));
        ifetch_ack = 1'($urandom_range(0, 1));
        #1;
        chk_reset_outs();
        next_cycle();
        noise();
        #1;
        chk_reset_outs();
        rst_n      = 1'b1;
        retire     = 1'b0;
        ifetch_ack = 1'b0;
        #1;
        chkb("load_wen", pc_wen, 1'b1);
        chk("load_pc_next", pc_next, RST_PC);
        chkb("load_req", ifetch_req, 1'b0);
        next_cycle();
        model_pc = RST_PC;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        reset_pulse();

        // sequential flow from reset: 0 then 4
        fetch(0, 1'b1);
        exec(0, 1'b0, 1'b0, 32'h0, 32'h0);
        update(0, 1'b1);
        fetch(0, 1'b1);
        exec(2, 1'b0, 1'b0, 32'h0, 32'h0);
        update(0, 1'b1);

        // ack withheld five cycles
        fetch(5, 1'b1);

        // trap wins over redirect
        exec(1, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0080);
        update(0, 1'b1);
        fetch(1, 1'b1);

        // misaligned redirect -> trap_vec with misalign pulse
        exec(0, 1'b0, 1'b1, 32'h0000_0102, 32'h0000_0200);
        update(0, 1'b1);
        fetch(0, 1'b1);

        // misalign pulse stays one cycle even while stalled
        exec(0, 1'b0, 1'b1, 32'h0000_0303, 32'h0000_0400);
        update(2, 1'b1);
        fetch(0, 1'b1);

        // wrap at top of address space under stall
        exec(0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0);
        update(0, 1'b1);
        fetch(0, 1'b1);
        exec(0, 1'b0, 1'b0, 32'h0, 32'h0);
        update(3, 1'b1);
        fetch(0, 1'b1);

        // reset while stalled in UPDATE
        exec(1, 1'b0, 1'b1, 32'h0000_0040, 32'h0);
        update(2, 1'b0);
        reset_pulse();

        // reset mid-fetch
        fetch(3, 1'b0);
        reset_pulse();

        for (int it = 0; it < 40; it++) begin
            logic        trap;
            logic        rv;
            logic [31:0] rpc;
            logic [31:0] tvec;
            trap = ($urandom_range(0, 3) == 0);
            rv   = 1'($urandom_range(0, 1));
            rpc  = $urandom;
            if ($urandom_range(0, 1) == 1) rpc = rpc & 32'hFFFF_FFFC;
            tvec = $urandom;
            fetch(int'($urandom_range(0, 4)), 1'b1);
            exec(int'($urandom_range(0, 3)), trap, rv, rpc, tvec);
            if (it % 10 == 9) begin
                update(int'($urandom_range(1, 3)), 1'b0);
                reset_pulse();
            end else begin
                update(int'($urandom_range(0, 3)), 1'b1);
            end
        end
        fetch(0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
